// File: rtl/seq_pkg.sv
// seq_pkg: shared state codes and pattern constants for the 10110 generator and detector
package seq_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S101  = 3'd3,
      S1011 = 3'd4
   } state_t;
   localparam int unsigned PAT_LEN = 5;
   localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;
   localparam logic [2:0] GEN_S0 = 3'd0;
   localparam logic [2:0] GEN_S1 = 3'd1;
   localparam logic [2:0] GEN_S2 = 3'd2;
   localparam logic [2:0] GEN_S3 = 3'd3;
   localparam logic [2:0] GEN_S4 = 3'd4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/seq_det_10110.sv
// seq_det_10110: strobed serial 10110 detector with overlap select and saturating match count
module seq_det_10110
   import seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   input  logic             overlap_en,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [2:0]       state_dbg
);
   state_t state_q;
   state_t state_d;
   logic   match_q;
   logic   match_d;
   always_comb begin
      state_d = state_q;
      match_d = 1'b0;
      if (din_vld)
         case (state_q)
            IDLE:    state_d = din ? S1 : IDLE;
            S1:      state_d = din ? S1 : S10;
            S10:     state_d = din ? S101 : IDLE;
            S101:    state_d = din ? S1011 : S10;
            S1011: begin
               state_d = din ? S1 : (overlap_en ? S10 : IDLE);
               match_d = !din;
            end
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
      end
   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (match_d),
      .cnt (match_cnt)
   );
   assign match     = match_q;
   assign state_dbg = state_q;
endmodule

// File: tb/tb_seq_det_10110.sv
// tb_seq_det_10110: randomized scoreboard bench against a suffix-history reference model
module tb_seq_det_10110;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_vld = 1'b0;
   logic       overlap_en = 1'b0;
   logic       clr = 1'b0;
   logic       match8;
   logic       match2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   logic [2:0] dbg8;
   logic [2:0] dbg2;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic       m;
      logic [7:0] c8;
      logic [1:0] c2;
      logic [2:0] s;
   } exp_t;
   exp_t exp_q[$];
   logic [4:0] hist = '0;
   int         hlen = 0;
   logic [7:0] m_c8 = '0;
   logic [1:0] m_c2 = '0;
   logic [2:0] m_s = '0;
   logic [4:0] pat = 5'b10110;
   always #5 clk = ~clk;
   seq_det_10110 #(.CNT_W(8)) u8 (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .overlap_en(overlap_en),
      .clr(clr), .match(match8), .match_cnt(cnt8), .state_dbg(dbg8)
   );
   seq_det_10110 #(.CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .overlap_en(overlap_en),
      .clr(clr), .match(match2), .match_cnt(cnt2), .state_dbg(dbg2)
   );
   task automatic model_edge();
      logic m;
      exp_t e;
      m = 1'b0;
      if (rst) begin
         hlen = 0;
         m_c8 = '0;
         m_c2 = '0;
      end else begin
         if (din_vld) begin
            hist = {hist[3:0], din};
            hlen = (hlen < 5) ? hlen + 1 : 5;
            m = (hlen == 5) && (hist == pat);
            if (m && !overlap_en) hlen = 0;
         end
         m_c8 = clr ? 8'd0 : (m && m_c8 != 8'hff) ? m_c8 + 8'd1 : m_c8;
         m_c2 = clr ? 2'd0 : (m && m_c2 != 2'd3) ? m_c2 + 2'd1 : m_c2;
      end
      m_s = 3'd0;
      for (int k = 4; k >= 1; k--)
         if (m_s == 3'd0 && hlen >= k && ((hist & 5'((1 << k) - 1)) == (pat >> (5 - k))))
            m_s = 3'(k);
      e.m = m;
      e.c8 = m_c8;
      e.c2 = m_c2;
      e.s = m_s;
      exp_q.push_back(e);
   endtask
   task automatic step(input logic d, input logic v, input logic o, input logic c, input logic r);
      din = d;
      din_vld = v;
      overlap_en = o;
      clr = c;
      rst = r;
      @(posedge clk);
      #1;
      model_edge();
   endtask
   task automatic send(input logic [15:0] bits, input int n, input logic o, input int gap, input logic clr_last);
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i], 1'b1, o, clr_last && i == 0, 1'b0);
         repeat (gap) step(1'b0, 1'b0, o, 1'b0, 1'b0);
      end
   endtask
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks += 5;
         if (match8 !== e.m) begin errors++; $display("FAIL match8 got=%b exp=%b t=%0t", match8, e.m, $time); end
         if (match2 !== e.m) begin errors++; $display("FAIL match2 got=%b exp=%b t=%0t", match2, e.m, $time); end
         if (cnt8 !== e.c8) begin errors++; $display("FAIL cnt8 got=%0d exp=%0d t=%0t", cnt8, e.c8, $time); end
         if (cnt2 !== e.c2) begin errors++; $display("FAIL cnt2 got=%0d exp=%0d t=%0t", cnt2, e.c2, $time); end
         if (dbg8 !== e.s || dbg2 !== e.s) begin errors++; $display("FAIL state_dbg got=%0d/%0d exp=%0d t=%0t", dbg8, dbg2, e.s, $time); end
      end
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      step(0, 0, 1, 0, 1);
      send(16'b10110, 5, 1'b1, 0, 1'b0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      send(16'b10110110, 8, 1'b1, 0, 1'b0);
      step(0, 0, 0, 0, 1);
      send(16'b10110110, 8, 1'b0, 0, 1'b0);
      step(0, 0, 0, 0, 1);
      send(16'b10110, 5, 1'b0, 3, 1'b0);
      step(0, 0, 0, 0, 1);
      send(16'b11010110, 8, 1'b0, 0, 1'b0);
      step(0, 0, 1, 0, 1);
      send(16'b10110, 5, 1'b1, 0, 1'b0);
      repeat (4) send(16'b110, 3, 1'b1, 1, 1'b0);
      send(16'b110, 3, 1'b1, 0, 1'b1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      send(16'b1011, 4, 1'b0, 0, 1'b0);
      step(0, 0, 0, 0, 1);
      send(16'b0, 1, 1'b0, 2, 1'b0);
      step(0, 0, 0, 0, 1);
      send(16'b101110110, 9, 1'b0, 1, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         logic d;
         logic v;
         d = ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0;
         v = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
         step(d, v, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0);
      end
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
